// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with locked
// data sequences. Define ARB_STARVE_GUARD_EN to enable the fetch anti-starvation guard.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          stall_if,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic          dm_lock,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, IF_OWN, DM_OWN, DM_LOCKED} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_IF, RD_DM} owner_t;

  state_t        state;
  owner_t        rd_owner_p1;
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] wdata_hold;
  logic [DW-1:0] if_hold;
  logic [DW-1:0] dm_hold;
  logic          force_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  assign force_if = if_req && (starve_cnt >= CW'(STARVE_MAX));

  // Locked data grants still count, so the guard fires as soon as the lock ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (if_gnt || !if_req)
      starve_cnt <= '0;
    else if (dm_gnt && (starve_cnt < CW'(STARVE_MAX)))
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^STARVE_MAX;
  assign force_if = 1'b0;
`endif

  // Grant decision: zero latency, suppressed while reset is asserted.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if (state == DM_LOCKED) begin
        dm_gnt = dm_req;
        if_gnt = if_req & ~dm_req;
      end else if (force_if) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
      end
    end
  end

  assign stall_if  = ~rst & if_req & ~if_gnt;
  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = dm_gnt & dm_we;
  assign mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : addr_hold);
  assign mem_wdata = dm_gnt ? dm_wdata : wdata_hold;

  // Read return stage: mem_rdata belongs to whoever was granted last cycle.
  assign if_valid = (rd_owner_p1 == RD_IF);
  assign dm_valid = (rd_owner_p1 == RD_DM);
  assign if_rdata = if_valid ? mem_rdata : if_hold;
  assign dm_rdata = dm_valid ? mem_rdata : dm_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_owner_p1 <= RD_NONE;
      addr_hold   <= '0;
      wdata_hold  <= '0;
      if_hold     <= '0;
      dm_hold     <= '0;
    end else begin
      if (dm_gnt)
        state <= dm_lock ? DM_LOCKED : DM_OWN;
      else if (if_gnt)
        state <= IF_OWN;
      else
        state <= IDLE;

      if (dm_gnt && !dm_we)
        rd_owner_p1 <= RD_DM;
      else if (if_gnt)
        rd_owner_p1 <= RD_IF;
      else
        rd_owner_p1 <= RD_NONE;

      if (mem_en)
        addr_hold <= mem_addr;
      if (dm_gnt)
        wdata_hold <= dm_wdata;
      if (if_valid)
        if_hold <= mem_rdata;
      if (dm_valid)
        dm_hold <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: rule-level grant model, queued read expectations.
module tb_mem_port_arbiter;
  localparam int AW = 8, DW = 8, STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 0, dm_req = 0, dm_we = 0, dm_lock = 0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          if_gnt, if_valid, stall_if, dm_gnt, dm_valid, mem_en, mem_we;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .stall_if(stall_if),
    .dm_req(dm_req), .dm_we(dm_we), .dm_lock(dm_lock), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory macro: synchronous read, write at the strobe edge.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    int            due;
    bit            to_dm;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  exp_t          me;
  logic [DW-1:0] ref_mem [256];
  int            checks = 0, errors = 0;

  bit            m_locked = 0;
  int            m_cnt = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] last_if = '0, last_dm = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares read returns whenever the DUT presents them.
  bit            ev_if, ev_dm;
  logic [DW-1:0] ed_if, ed_dm;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_if_gnt", if_gnt, 0);     chk("rst_dm_gnt", dm_gnt, 0);
        chk("rst_if_valid", if_valid, 0); chk("rst_dm_valid", dm_valid, 0);
        chk("rst_mem_en", mem_en, 0);     chk("rst_mem_we", mem_we, 0);
        chk("rst_stall_if", stall_if, 0); chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0); chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        last_if = '0;
        last_dm = '0;
      end else begin
        ev_if = 0; ev_dm = 0; ed_if = last_if; ed_dm = last_dm;
        while (q.size() > 0 && q[0].due < cyc) begin
          me = q.pop_front();
          chk("read_return_missing", 0, 1);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          me = q.pop_front();
          if (me.to_dm) begin ev_dm = 1; ed_dm = me.data; end
          else          begin ev_if = 1; ed_if = me.data; end
        end
        chk("if_valid", if_valid, ev_if);
        chk("dm_valid", dm_valid, ev_dm);
        chk("if_rdata", if_rdata, ed_if);
        chk("dm_rdata", dm_rdata, ed_dm);
        last_if = ed_if;
        last_dm = ed_dm;
      end
    end
  end

  // One arbitration cycle: drive requests, derive the expected grant from the rules.
  task automatic step(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                      input bit dl, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bit e_i, e_d;
    @(negedge clk);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_lock = dl;
    dm_addr = da; dm_wdata = dd;
    #1;
    e_i = 0; e_d = 0;
    if (m_locked) begin
      e_d = dr;
      e_i = ir && !dr;
    end
`ifdef ARB_STARVE_GUARD_EN
    else if (ir && m_cnt >= STARVE_MAX) e_i = 1;
`endif
    else if (dr) e_d = 1;
    else e_i = ir;

    chk("if_gnt", if_gnt, e_i);
    chk("dm_gnt", dm_gnt, e_d);
    chk("stall_if", stall_if, ir && !e_i);
    chk("mem_en", mem_en, e_i || e_d);
    chk("mem_we", mem_we, e_d && dw);
    if (e_d) m_addr = da;
    else if (e_i) m_addr = ia;
    chk("mem_addr", mem_addr, m_addr);
    if (e_d && dw) begin
      chk("mem_wdata", mem_wdata, dd);
      ref_mem[da] = dd;
    end
    if (e_d && !dw) q.push_back('{cyc + 1, 1'b1, ref_mem[da]});
    if (e_i)        q.push_back('{cyc + 1, 1'b0, ref_mem[ia]});

    m_locked = e_d && dl;
    if (e_i || !ir) m_cnt = 0;
    else if (e_d && m_cnt < STARVE_MAX) m_cnt++;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1;
    q.delete();
    m_locked = 0; m_cnt = 0; m_addr = '0;
    @(negedge clk);
    if_req = 1; dm_req = 1; dm_lock = 1; dm_we = 0;
    #1;
    chk("rst_hold_if_gnt", if_gnt, 0);
    chk("rst_hold_dm_gnt", dm_gnt, 0);
    @(posedge clk);
    #1 rst = 0;
    if_req = 0; dm_req = 0; dm_lock = 0;
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'hC1; ref_mem[8'h10] = 8'hC1;
    mem[8'h1F] = 8'hA5; ref_mem[8'h1F] = 8'hA5;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 0;

    // Lone fetch, then simultaneous fetch and data read.
    step(1, 8'h10, 0, 0, 0, '0, '0);
    idle();
    step(1, 8'h20, 1, 0, 0, 8'h1F, '0);
    step(1, 8'h20, 0, 0, 0, '0, '0);
    idle();
    // Write then read-after-write.
    step(0, '0, 1, 1, 0, 8'hFF, 8'hB7);
    step(0, '0, 1, 0, 0, 8'hFF, '0);
    idle();
    // Locked push sequence with fetch waiting.
    for (int i = 0; i < 3; i++) step(1, 8'h30, 1, 1, 1, 8'hF0 - 8'(i), 8'(i));
    step(1, 8'h30, 0, 0, 0, '0, '0);
    idle();
    // Sustained contention.
    for (int i = 0; i < 12; i++) step(1, 8'h40 + 8'(i), 1, 0, 0, 8'h50 + 8'(i), '0);
    idle();
    // Reset one cycle after a data read grant, then a fresh fetch.
    step(0, '0, 1, 0, 0, 8'h1F, '0);
    pulse_reset();
    step(1, 8'h10, 0, 0, 0, '0, '0);
    idle();
    step(0, '0, 0, 0, 1, '0, '0);
    idle();

    // Randomized traffic with occasional mid-stream reset.
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] ra, rd;
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      rd = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, ra, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, rd, DW'($urandom));
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end

    idle();
    idle();
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
